// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm
//   Main control FSM for a multicycle RV32I datapath with a shared ALU and a
//   shared instruction/data memory. Each instruction walks through FETCH,
//   DECODE and then an opcode-specific path (MEMADR/MEMREAD/MEMWB,
//   MEMADR/MEMWRITE, EXECR/EXECI/ALUWB, BEQ, JAL/ALUWB). Unsupported opcodes
//   park the FSM in TRAP with a sticky illegal flag until reset.
//
// Parameters
//   MEM_LAT  extra wait cycles per memory access (FETCH, MEMREAD, MEMWRITE)
//   CNT_W    width of the wait-state counter, MEM_LAT < 2**CNT_W
//
// Ports
//   clk, reset_n            rising-edge clock, asynchronous active-low reset
//   op[6:0], zero           opcode from the instruction register, ALU zero flag
//   pcWrite, adrSrc, irWrite, memWrite, regWrite
//                           datapath enables and the memory address select
//   resultSrc, aluSrcA, aluSrcB, ALUOp
//                           datapath mux selects and the ALU decoder hint
//   immSrc[2:0]             immediate format, combinational from op
//   instrDone               one-cycle pulse in the last cycle of an instruction
//   illegal                 sticky: an unsupported opcode reached DECODE
//   state[3:0]              current state encoding for debug
//
// Optional feature
//   RV_UPPER_IMM_EN  adds lui (LUI state) and auipc (AUIPC state); when it is
//   undefined both opcodes trap and immSrc=100 / resultSrc=11 never occur.
//
// Handshake: there is none; the datapath is slave to the Moore outputs and the
//   memory is assumed ready after exactly MEM_LAT+1 cycles of each access.

module multicycle_main_fsm #(
  parameter int MEM_LAT = 0,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic       zero,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       irWrite,
  output logic       memWrite,
  output logic       regWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] immSrc,
  output logic       instrDone,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;
  localparam logic [3:0] S_LUI      = 4'd12;
  localparam logic [3:0] S_AUIPC    = 4'd13;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;

  logic mem_state;
  logic last;
  logic pc_update, branch;
  logic ir_write_raw, mem_write_raw, reg_write_raw;

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                     (state_q == S_MEMWRITE);
  assign last      = (cnt_q == LAT);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:    if (last) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef RV_UPPER_IMM_EN
          OP_LUI:       state_d = S_LUI;
          OP_AUIPC:     state_d = S_AUIPC;
`endif
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      // Only lw/sw reach MEMADR; op[5] is the bit that separates them.
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (last) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (last) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
`ifdef RV_UPPER_IMM_EN
      S_LUI:      state_d = S_FETCH;
      S_AUIPC:    state_d = S_ALUWB;
`endif
      default:    state_d = S_FETCH;
    endcase
    // Counter restarts at 0 on every state entry; it only runs while a
    // memory state is waiting (not yet at its last cycle).
    cnt_d = (mem_state && !last) ? cnt_q + 1'b1 : '0;
  end

  // Output logic (Moore)
  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    adrSrc        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    resultSrc     = 2'b00;
    aluSrcA       = 2'b00;
    aluSrcB       = 2'b00;
    ALUOp         = 2'b00;
    instrDone     = 1'b0;
    case (state_q)
      S_FETCH: begin
        aluSrcB      = 2'b10;
        resultSrc    = 2'b10;
        ir_write_raw = last;
        pc_update    = last;
      end
      S_DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
      end
      S_MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
      end
      S_MEMREAD:  adrSrc = 1'b1;
      S_MEMWB: begin
        resultSrc     = 2'b01;
        reg_write_raw = 1'b1;
        instrDone     = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrc        = 1'b1;
        mem_write_raw = last;
        instrDone     = last;
      end
      S_EXECR: begin
        aluSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        instrDone     = 1'b1;
      end
      S_BEQ: begin
        aluSrcA   = 2'b10;
        ALUOp     = 2'b01;
        branch    = 1'b1;
        instrDone = 1'b1;
      end
      S_JAL: begin
        aluSrcA   = 2'b01;
        aluSrcB   = 2'b10;
        pc_update = 1'b1;
      end
`ifdef RV_UPPER_IMM_EN
      S_LUI: begin
        resultSrc     = 2'b11;
        reg_write_raw = 1'b1;
        instrDone     = 1'b1;
      end
      S_AUIPC: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
      end
`endif
      default: ;
    endcase
  end

  // Immediate format is a pure function of the opcode.
  always_comb begin
    case (op)
      OP_SW:    immSrc = 3'b001;
      OP_BEQ:   immSrc = 3'b010;
      OP_JAL:   immSrc = 3'b011;
`ifdef RV_UPPER_IMM_EN
      OP_LUI,
      OP_AUIPC: immSrc = 3'b100;
`endif
      default:  immSrc = 3'b000;
    endcase
  end

  // Write enables are held off for as long as reset is asserted, even though
  // the state register already shows FETCH.
  assign pcWrite  = reset_n & (pc_update | (branch & zero));
  assign irWrite  = reset_n & ir_write_raw;
  assign memWrite = reset_n & mem_write_raw;
  assign regWrite = reset_n & reg_write_raw;
  assign illegal  = illegal_q;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb_multicycle_main_fsm
//   Bench for multicycle_main_fsm. Three instances with MEM_LAT = 0, 2, 3
//   share op/zero; each has its own reset so only one runs at a time.
//   Per-cycle expected output vectors are queued when an instruction is
//   driven and compared one per cycle, half a period after the clock edge.

module tb_multicycle_main_fsm;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;
  localparam logic [3:0] S_LUI      = 4'd12;
  localparam logic [3:0] S_AUIPC    = 4'd13;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  localparam int W = 22;

  // ---------------- clock / reset / DUTs ----------------
  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [6:0] op;
  logic       zero;

  logic       pc_write   [3];
  logic       adr_src    [3];
  logic       ir_write   [3];
  logic       mem_write  [3];
  logic       reg_write  [3];
  logic [1:0] result_src [3];
  logic [1:0] alu_src_a  [3];
  logic [1:0] alu_src_b  [3];
  logic [1:0] alu_op     [3];
  logic [2:0] imm_src    [3];
  logic       instr_done [3];
  logic       illegal_w  [3];
  logic [3:0] state_w    [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    multicycle_main_fsm #(.MEM_LAT(LAT), .CNT_W(4)) u_dut (
      .clk       (clk),
      .reset_n   (rst_n[g]),
      .op        (op),
      .zero      (zero),
      .pcWrite   (pc_write[g]),
      .adrSrc    (adr_src[g]),
      .irWrite   (ir_write[g]),
      .memWrite  (mem_write[g]),
      .regWrite  (reg_write[g]),
      .resultSrc (result_src[g]),
      .aluSrcA   (alu_src_a[g]),
      .aluSrcB   (alu_src_b[g]),
      .ALUOp     (alu_op[g]),
      .immSrc    (imm_src[g]),
      .instrDone (instr_done[g]),
      .illegal   (illegal_w[g]),
      .state     (state_w[g])
    );
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           vectors    = 0;
  int           miscompares = 0;
  int           glitch_k   = -1;
  logic [6:0]   glitch_op  = 7'd0;

  task automatic check_vec(input string tag, input logic [W-1:0] got,
                           input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
               tag, got[W-1 -: 4], got, exp[W-1 -: 4], exp);
    end
  endtask

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      OP_SW:    return 3'b001;
      OP_BEQ:   return 3'b010;
      OP_JAL:   return 3'b011;
`ifdef RV_UPPER_IMM_EN
      OP_LUI,
      OP_AUIPC: return 3'b100;
`endif
      default:  return 3'b000;
    endcase
  endfunction

  // {state, pcWrite, adrSrc, irWrite, memWrite, regWrite, resultSrc,
  //  aluSrcA, aluSrcB, ALUOp, immSrc, instrDone, illegal}
  function automatic logic [W-1:0] mk(
      input logic [3:0] st, input logic pcw, input logic adr, input logic irw,
      input logic memw, input logic regw, input logic [1:0] rs,
      input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] aop,
      input logic done, input logic ill, input logic [6:0] o);
    return {st, pcw, adr, irw, memw, regw, rs, sa, sb, aop, imm_of(o), done, ill};
  endfunction

  function automatic logic [W-1:0] obs(input int s);
    return {state_w[s], pc_write[s], adr_src[s], ir_write[s], mem_write[s],
            reg_write[s], result_src[s], alu_src_a[s], alu_src_b[s],
            alu_op[s], imm_src[s], instr_done[s], illegal_w[s]};
  endfunction

  function automatic logic [W-1:0] rst_rec(input logic [6:0] o);
    return mk(S_FETCH, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, o);
  endfunction

  // Expected cycle-by-cycle trace of one instruction starting in FETCH.
  task automatic push_instr(input int lat, input logic [6:0] o, input logic z,
                            input int ntrap);
    for (int i = 0; i <= lat; i++)
      exp_q.push_back(mk(S_FETCH, i == lat, 0, i == lat, 0, 0, 2'b10, 2'b00,
                         2'b10, 2'b00, 0, 0, o));
    exp_q.push_back(mk(S_DECODE, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0, o));
    case (o)
      OP_LW: begin
        exp_q.push_back(mk(S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, o));
        for (int i = 0; i <= lat; i++)
          exp_q.push_back(mk(S_MEMREAD, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, o));
        exp_q.push_back(mk(S_MEMWB, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, o));
      end
      OP_SW: begin
        exp_q.push_back(mk(S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, o));
        for (int i = 0; i <= lat; i++)
          exp_q.push_back(mk(S_MEMWRITE, 0, 1, 0, i == lat, 0, 2'b00, 2'b00, 2'b00,
                             2'b00, i == lat, 0, o));
      end
      OP_R: begin
        exp_q.push_back(mk(S_EXECR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, o));
        exp_q.push_back(mk(S_ALUWB, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, o));
      end
      OP_I: begin
        exp_q.push_back(mk(S_EXECI, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0, o));
        exp_q.push_back(mk(S_ALUWB, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, o));
      end
      OP_BEQ:
        exp_q.push_back(mk(S_BEQ, z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 1, 0, o));
      OP_JAL: begin
        exp_q.push_back(mk(S_JAL, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, o));
        exp_q.push_back(mk(S_ALUWB, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, o));
      end
`ifdef RV_UPPER_IMM_EN
      OP_LUI:
        exp_q.push_back(mk(S_LUI, 0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, o));
      OP_AUIPC: begin
        exp_q.push_back(mk(S_AUIPC, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0, o));
        exp_q.push_back(mk(S_ALUWB, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, o));
      end
`endif
      default:
        for (int i = 0; i < ntrap; i++)
          exp_q.push_back(mk(S_TRAP, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, o));
    endcase
  endtask

  // Pop and compare one expected vector per cycle; entered at a falling edge.
  task automatic drain(input int s, input string name, input int max_n);
    int k = 0;
    while (exp_q.size() > 0 && k < max_n) begin
      logic [W-1:0] e;
      if (k == glitch_k) op = glitch_op;
      #1;
      e = exp_q.pop_front();
      check_vec($sformatf("%s/c%0d", name, k), obs(s), e);
      k++;
      @(negedge clk);
    end
    exp_q.delete();
    glitch_k = -1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_instr(input int s, input int lat, input logic [6:0] o,
                           input logic z, input int ntrap, input string name);
    op   = o;
    zero = z;
    push_instr(lat, o, z, ntrap);
    drain(s, name, 1000);
  endtask

  task automatic hold_reset(input int s, input int n, input string name);
    rst_n[s] = 1'b0;
    for (int i = 0; i < n; i++) exp_q.push_back(rst_rec(op));
    drain(s, name, 1000);
  endtask

  task automatic run_random(input int s, input int lat, input int n);
    logic [6:0] ops_tab [6];
    ops_tab = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
    for (int i = 0; i < n; i++) begin
      logic [6:0] o;
      logic       z;
      o = ops_tab[$urandom_range(0, 5)];
      z = 1'($urandom_range(0, 1));
      run_instr(s, lat, o, z, 0, $sformatf("rnd%0d_%0d_op%b", lat, i, o));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 3'b111;
    op    = OP_R;
    zero  = 1'b0;
    #1 rst_n = 3'b000;
    @(negedge clk);

    // Reset: FETCH values with all write enables off, even at MEM_LAT=0.
    hold_reset(0, 2, "rst_lat0");
    hold_reset(1, 1, "rst_lat2");

    // MEM_LAT = 0
    rst_n[0] = 1'b1;
    run_instr(0, 0, OP_LW,  0, 0, "lw_lat0");
    run_instr(0, 0, OP_SW,  0, 0, "sw_lat0");
    run_instr(0, 0, OP_R,   0, 0, "r_lat0");
    run_instr(0, 0, OP_I,   1, 0, "i_lat0");
    run_instr(0, 0, OP_BEQ, 1, 0, "beq_z1");
    run_instr(0, 0, OP_BEQ, 0, 0, "beq_z0");
    run_instr(0, 0, OP_JAL, 0, 0, "jal_lat0");
    // op changes while in EXECR must not alter the path.
    glitch_k  = 2;
    glitch_op = OP_BAD;
    run_instr(0, 0, OP_R,   0, 0, "r_opchg");
    run_random(0, 0, 6);
    run_instr(0, 0, OP_LUI, 0, 3, "lui");
    hold_reset(0, 1, "rst_lui");
    rst_n[0] = 1'b1;
    run_instr(0, 0, OP_AUIPC, 0, 3, "auipc");
    hold_reset(0, 1, "rst_auipc");

    // MEM_LAT = 2
    rst_n[1] = 1'b1;
    run_instr(1, 2, OP_SW,  0, 0, "sw_lat2");
    run_instr(1, 2, OP_LW,  0, 0, "lw_lat2");
    run_instr(1, 2, OP_BEQ, 1, 0, "beq_lat2");
    run_random(1, 2, 6);
    hold_reset(1, 1, "rst_lat2_end");

    // MEM_LAT = 3: trap, recovery, reset in the middle of MEMWRITE
    hold_reset(2, 1, "rst_lat3");
    rst_n[2] = 1'b1;
    run_instr(2, 3, OP_BAD, 0, 20, "trap");
    hold_reset(2, 2, "rst_trap");
    rst_n[2] = 1'b1;
    op = OP_SW;
    push_instr(3, OP_SW, 0, 0);
    drain(2, "sw_cut", 8);
    hold_reset(2, 2, "rst_midwr");
    rst_n[2] = 1'b1;
    run_instr(2, 3, OP_R, 0, 0, "r_after_rst");
    run_instr(2, 3, OP_LW, 0, 0, "lw_lat3");
    hold_reset(2, 1, "rst_lat3_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
